// File: rtl/sim_reset_watchdog_if.sv
// Harness-facing signal bundle of the reset/run watchdog: restart and GPIO observation in,
// DUT resets and run status out.
interface sim_reset_watchdog_if #(
  parameter int N_DOMAINS = 2,
  parameter int GPIO_W    = 32
);
  logic                 restart_i;
  logic [GPIO_W-1:0]    gpio_i;
  logic [GPIO_W-1:0]    gpio_en_i;
  logic [N_DOMAINS-1:0] dut_rst_no;
  logic                 running_o;
  logic                 done_o;
  logic                 pass_o;
  logic                 fail_o;
  logic                 timeout_o;
  logic [31:0]          cycle_cnt_o;

  modport master (
    output restart_i, gpio_i, gpio_en_i,
    input  dut_rst_no, running_o, done_o, pass_o, fail_o, timeout_o, cycle_cnt_o
  );

  modport slave (
    input  restart_i, gpio_i, gpio_en_i,
    output dut_rst_no, running_o, done_o, pass_o, fail_o, timeout_o, cycle_cnt_o
  );
endinterface

// File: rtl/sim_reset_watchdog.sv
// Run controller: sequences the DUT resets (idle, assert, staggered release), then watches
// GPIO for a stable pass/fail signature or a cycle timeout. All outputs are registered.
module sim_reset_watchdog #(
  parameter int              N_DOMAINS      = 2,
  parameter int              PRE_CYCLES     = 2,
  parameter int              ASSERT_CYCLES  = 3,
  parameter int              STAGGER        = 4,
  parameter int              TIMEOUT_CYCLES = 500,
  parameter int              STABLE_CYCLES  = 4,
  parameter int              GPIO_W         = 32,
  parameter logic [GPIO_W-1:0] CODE_MASK    = 32'hFFFF_0000,
  parameter logic [GPIO_W-1:0] PASS_CODE    = 32'hC0DE_0000,
  parameter logic [GPIO_W-1:0] FAIL_CODE    = 32'hDEAD_0000
) (
  input logic                 clk_i,
  input logic                 rst_i,
  sim_reset_watchdog_if.slave bus
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int REL_LAST = (N_DOMAINS - 1) * STAGGER;
  localparam int PH_MAX   = max3(PRE_CYCLES, ASSERT_CYCLES, REL_LAST + 1);
  localparam int PH_W     = $clog2(PH_MAX + 1);
  localparam int MC_W     = $clog2(STABLE_CYCLES + 1);

  localparam logic [PH_W-1:0]   PRE_LAST    = PH_W'(PRE_CYCLES - 1);
  localparam logic [PH_W-1:0]   ASSERT_LAST = PH_W'(ASSERT_CYCLES - 1);
  localparam logic [PH_W-1:0]   REL_END     = PH_W'(REL_LAST);
  localparam logic [MC_W-1:0]   MC_LAST     = MC_W'(STABLE_CYCLES - 1);
  localparam logic [31:0]       RUN_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [GPIO_W-1:0] PASS_SIG    = PASS_CODE & CODE_MASK;
  localparam logic [GPIO_W-1:0] FAIL_SIG    = FAIL_CODE & CODE_MASK;

  typedef enum logic [2:0] {
    S_PRE     = 3'd0,
    S_ASSERT  = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [PH_W-1:0] sat_inc_ph(input logic [PH_W-1:0] v);
    return (v == {PH_W{1'b1}}) ? v : v + PH_W'(1);
  endfunction

  function automatic logic [MC_W-1:0] sat_inc_mc(input logic [MC_W-1:0] v);
    return (v == MC_LAST) ? v : v + MC_W'(1);
  endfunction

  // Domain k is out of reset once the phase has reached k*STAGGER.
  function automatic logic [N_DOMAINS-1:0] release_mask(input logic [PH_W-1:0] ph);
    logic [N_DOMAINS-1:0] m;
    m = '0;
    for (int k = 0; k < N_DOMAINS; k++) begin
      m[k] = (32'(ph) >= 32'(k * STAGGER));
    end
    return m;
  endfunction

  state_t               state_q, state_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [MC_W-1:0]      pass_mc_q, pass_mc_d;
  logic [MC_W-1:0]      fail_mc_q, fail_mc_d;
  logic [31:0]          cycle_q, cycle_d;
  logic [N_DOMAINS-1:0] dut_rst_q, dut_rst_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 timeout_q, timeout_d;

  logic code_valid, pass_hit, fail_hit;
  logic pass_accept, fail_accept, run_expired, restart_go;

  assign code_valid  = ((bus.gpio_en_i & CODE_MASK) == CODE_MASK);
  assign pass_hit    = code_valid && ((bus.gpio_i & CODE_MASK) == PASS_SIG);
  assign fail_hit    = code_valid && ((bus.gpio_i & CODE_MASK) == FAIL_SIG);
  // Acceptance fires on the sample that brings the streak to STABLE_CYCLES.
  assign pass_accept = (state_q == S_RUN) && pass_hit && (pass_mc_q == MC_LAST);
  assign fail_accept = (state_q == S_RUN) && fail_hit && (fail_mc_q == MC_LAST);
  assign run_expired = (state_q == S_RUN) && (cycle_q == RUN_LAST);
  assign restart_go  = (state_q == S_DONE) && bus.restart_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_PRE;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PRE:     if (ph_q == PRE_LAST)    state_d = S_ASSERT;
      S_ASSERT:  if (ph_q == ASSERT_LAST) state_d = S_RELEASE;
      S_RELEASE: if (ph_q == REL_END)     state_d = S_RUN;
      S_RUN:     if (fail_accept || pass_accept || run_expired) state_d = S_DONE;
      S_DONE:    if (bus.restart_i)       state_d = S_PRE;
      default:   state_d = S_PRE;
    endcase
    ph_d = (state_d != state_q) ? '0 : sat_inc_ph(ph_q);
  end

  always_comb begin
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
    case (state_d)
      S_ASSERT:  dut_rst_d = '0;
      S_RELEASE: dut_rst_d = release_mask(ph_d);
      default:   dut_rst_d = '1;
    endcase

    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    cycle_d   = cycle_q;
    pass_mc_d = pass_mc_q;
    fail_mc_d = fail_mc_q;

    if (restart_go) begin
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
      cycle_d   = '0;
      pass_mc_d = '0;
      fail_mc_d = '0;
    end else if (state_q == S_RUN) begin
      pass_mc_d = pass_hit ? sat_inc_mc(pass_mc_q) : '0;
      fail_mc_d = fail_hit ? sat_inc_mc(fail_mc_q) : '0;
      if (state_d == S_RUN) begin
        cycle_d = sat_inc32(cycle_q);
      end else begin
        // Leaving RUN: exactly one cause wins, fail over pass over timeout.
        fail_d    = fail_accept;
        pass_d    = pass_accept && !fail_accept;
        timeout_d = !fail_accept && !pass_accept;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dut_rst_q <= '1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      cycle_q   <= '0;
      pass_mc_q <= '0;
      fail_mc_q <= '0;
    end else begin
      dut_rst_q <= dut_rst_d;
      running_q <= running_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      cycle_q   <= cycle_d;
      pass_mc_q <= pass_mc_d;
      fail_mc_q <= fail_mc_d;
    end
  end

  assign bus.dut_rst_no  = dut_rst_q;
  assign bus.running_o   = running_q;
  assign bus.done_o      = done_q;
  assign bus.pass_o      = pass_q;
  assign bus.fail_o      = fail_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.cycle_cnt_o = cycle_q;

endmodule

// File: tb/tb_sim_reset_watchdog.sv
// Directed bench for sim_reset_watchdog: reset-sequence table plus hand-written run scenarios
// on a default instance and a 3-domain, zero-stagger instance.
module tb_sim_reset_watchdog;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sim_reset_watchdog_if #(.N_DOMAINS(2), .GPIO_W(32)) bus ();
  sim_reset_watchdog_if #(.N_DOMAINS(3), .GPIO_W(32)) bus3 ();

  sim_reset_watchdog u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  sim_reset_watchdog #(.N_DOMAINS(3), .STAGGER(0)) u_dut3 (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus3)
  );

  assign bus3.restart_i = bus.restart_i;
  assign bus3.gpio_i    = '0;
  assign bus3.gpio_en_i = '0;

  always #5 clk = ~clk;

  typedef struct {
    logic        restart;
    logic [31:0] gpio;
    logic [31:0] gpio_en;
    logic [1:0]  exp_rst;
    logic [2:0]  exp_rst3;
    logic        exp_running;
    logic        exp_done;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_restart();
    bus.restart_i = 1'b1;
    tick();
    bus.restart_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (bus.done_o !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("wait_done", 32'(bus.done_o), 32'd1);
  endtask

  task automatic wait_running(input int limit);
    int n;
    n = 0;
    while (bus.running_o !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check("wait_running", 32'(bus.running_o), 32'd1);
  endtask

  task automatic wait_cnt(input logic [31:0] target, input int limit);
    int n;
    n = 0;
    while (bus.cycle_cnt_o !== target && n < limit) begin
      tick();
      n++;
    end
    check("wait_cnt", bus.cycle_cnt_o, target);
  endtask

  // Entry i is checked after i edges from reset/restart; its inputs then drive edge i+1.
  task automatic run_table(input bit with3);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      check($sformatf("tbl%0d_rst", i), 32'(bus.dut_rst_no), 32'(vecs[i].exp_rst));
      check($sformatf("tbl%0d_running", i), 32'(bus.running_o), 32'(vecs[i].exp_running));
      check($sformatf("tbl%0d_done", i), 32'(bus.done_o), 32'(vecs[i].exp_done));
      check($sformatf("tbl%0d_cnt", i), bus.cycle_cnt_o, vecs[i].exp_cnt);
      if (with3) check($sformatf("tbl%0d_rst3", i), 32'(bus3.dut_rst_no), 32'(vecs[i].exp_rst3));
      bus.restart_i = vecs[i].restart;
      bus.gpio_i    = vecs[i].gpio;
      bus.gpio_en_i = vecs[i].gpio_en;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // restart and a held fail code during PRE/ASSERT/RELEASE must both be ignored
    vecs[0]  = '{1'b0, 32'h0,         32'h0,         2'b11, 3'b111, 1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 32'hDEAD_0000, 32'hFFFF_0000, 2'b11, 3'b111, 1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 32'hDEAD_0000, 32'hFFFF_0000, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0};
    vecs[3]  = '{1'b0, 32'hDEAD_0000, 32'hFFFF_0000, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0};
    vecs[4]  = '{1'b0, 32'hDEAD_0000, 32'hFFFF_0000, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0};
    vecs[5]  = '{1'b0, 32'hDEAD_0000, 32'hFFFF_0000, 2'b01, 3'b111, 1'b0, 1'b0, 32'd0};
    vecs[6]  = '{1'b0, 32'hDEAD_0000, 32'hFFFF_0000, 2'b01, 3'b111, 1'b0, 1'b0, 32'd0};
    vecs[7]  = '{1'b0, 32'hDEAD_0000, 32'hFFFF_0000, 2'b01, 3'b111, 1'b0, 1'b0, 32'd0};
    vecs[8]  = '{1'b0, 32'hDEAD_0000, 32'hFFFF_0000, 2'b01, 3'b111, 1'b0, 1'b0, 32'd0};
    vecs[9]  = '{1'b0, 32'h0,         32'h0,         2'b11, 3'b111, 1'b0, 1'b0, 32'd0};
    vecs[10] = '{1'b0, 32'h0,         32'h0,         2'b11, 3'b111, 1'b1, 1'b0, 32'd0};

    bus.restart_i = 1'b0;
    bus.gpio_i    = '0;
    bus.gpio_en_i = '0;

    // Reset values
    repeat (3) tick();
    check("rst_dut_rst", 32'(bus.dut_rst_no), 32'h3);
    check("rst_dut_rst3", 32'(bus3.dut_rst_no), 32'h7);
    check("rst_running", 32'(bus.running_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_flags", {29'd0, bus.pass_o, bus.fail_o, bus.timeout_o}, 32'd0);
    check("rst_cnt", bus.cycle_cnt_o, 32'd0);
    rst = 1'b0;

    // T1 idle run to timeout, with a restart pulse in RUN that must be ignored
    run_table(1'b1);
    wait_cnt(32'd100, 200);
    do_restart();
    check("t5_run_restart_running", 32'(bus.running_o), 32'd1);
    check("t5_run_restart_cnt", bus.cycle_cnt_o, 32'd101);
    wait_done(600);
    check("t1_timeout", 32'(bus.timeout_o), 32'd1);
    check("t1_pass_fail", {30'd0, bus.pass_o, bus.fail_o}, 32'd0);
    check("t1_running", 32'(bus.running_o), 32'd0);
    check("t1_cnt", bus.cycle_cnt_o, 32'd499);
    check("t1_dut_rst", 32'(bus.dut_rst_no), 32'h3);
    repeat (3) tick();
    check("t1_hold_done", 32'(bus.done_o), 32'd1);
    check("t1_hold_cnt", bus.cycle_cnt_o, 32'd499);
    check("t1_hold_timeout", 32'(bus.timeout_o), 32'd1);

    // T5 restart in DONE replays the full sequence
    do_restart();
    check("t5_timeout_clr", 32'(bus.timeout_o), 32'd0);
    check("t5_done_clr", 32'(bus.done_o), 32'd0);
    run_table(1'b1);

    // T2 pass code from RUN cycle 10
    wait_cnt(32'd10, 20);
    bus.gpio_i    = 32'hC0DE_0000;
    bus.gpio_en_i = 32'hFFFF_0000;
    wait_done(20);
    check("t2_pass", 32'(bus.pass_o), 32'd1);
    check("t2_fail_timeout", {30'd0, bus.fail_o, bus.timeout_o}, 32'd0);
    check("t2_cnt", bus.cycle_cnt_o, 32'd13);
    bus.gpio_i    = '0;
    bus.gpio_en_i = '0;

    // T3 fail streak of 3, one miss, then 4
    do_restart();
    check("t3_pass_clr", 32'(bus.pass_o), 32'd0);
    wait_running(20);
    wait_cnt(32'd5, 10);
    bus.gpio_en_i = 32'hFFFF_0000;
    bus.gpio_i    = 32'hDEAD_0000;
    repeat (3) tick();
    bus.gpio_i    = 32'h0;
    tick();
    check("t3_after_miss_done", 32'(bus.done_o), 32'd0);
    bus.gpio_i    = 32'hDEAD_0000;
    repeat (3) tick();
    check("t3_streak3_done", 32'(bus.done_o), 32'd0);
    check("t3_streak3_fail", 32'(bus.fail_o), 32'd0);
    check("t3_streak3_cnt", bus.cycle_cnt_o, 32'd12);
    tick();
    check("t3_done", 32'(bus.done_o), 32'd1);
    check("t3_fail", 32'(bus.fail_o), 32'd1);
    check("t3_pass_timeout", {30'd0, bus.pass_o, bus.timeout_o}, 32'd0);
    check("t3_cnt", bus.cycle_cnt_o, 32'd12);
    bus.gpio_i    = '0;
    bus.gpio_en_i = '0;

    // T4 pass streak ending on the timeout cycle; unmasked bits carry noise
    do_restart();
    wait_running(20);
    wait_cnt(32'd496, 600);
    bus.gpio_i    = 32'hC0DE_1234;
    bus.gpio_en_i = 32'hFFFF_00F0;
    wait_done(10);
    check("t4p_pass", 32'(bus.pass_o), 32'd1);
    check("t4p_timeout", 32'(bus.timeout_o), 32'd0);
    check("t4p_fail", 32'(bus.fail_o), 32'd0);
    check("t4p_cnt", bus.cycle_cnt_o, 32'd499);
    bus.gpio_i    = '0;
    bus.gpio_en_i = '0;

    do_restart();
    wait_running(20);
    wait_cnt(32'd496, 600);
    bus.gpio_i    = 32'hDEAD_8001;
    bus.gpio_en_i = 32'hFFFF_0001;
    wait_done(10);
    check("t4f_fail", 32'(bus.fail_o), 32'd1);
    check("t4f_timeout", 32'(bus.timeout_o), 32'd0);
    check("t4f_pass", 32'(bus.pass_o), 32'd0);
    check("t4f_cnt", bus.cycle_cnt_o, 32'd499);
    bus.gpio_i    = '0;
    bus.gpio_en_i = '0;

    // T6 asynchronous reset in RELEASE with bit 0 already high
    do_restart();
    begin
      int n;
      n = 0;
      while (bus.dut_rst_no !== 2'b01 && n < 20) begin
        tick();
        n++;
      end
    end
    check("t6_in_release", 32'(bus.dut_rst_no), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_rst", 32'(bus.dut_rst_no), 32'h3);
    check("t6_async_rst3", 32'(bus3.dut_rst_no), 32'h7);
    check("t6_async_running", 32'(bus.running_o), 32'd0);
    check("t6_async_done", 32'(bus.done_o), 32'd0);
    check("t6_async_cnt", bus.cycle_cnt_o, 32'd0);
    tick();
    check("t6_rst_held", 32'(bus.dut_rst_no), 32'h3);
    rst = 1'b0;
    run_table(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
